instr_mem_responder: RTL and testbench

//  Responder end of the instruction-fetch handshake: accepts a fetch request (syn + address),

---
 rtl/instr_mem_responder_pkg.sv | 15 +
 rtl/instr_mem_array.sv | 30 +++
 rtl/instr_mem_responder.sv | 119 +++++++++++
 tb/tb_instr_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared fetch-side definitions: NOP encoding,
// default word width and responder FSM states.
package instr_mem_responder_pkg;

  localparam int IM_IWIDTH = 32;

  localparam logic [31:0] IM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IM_IDLE = 2'd0,
    IM_WAIT = 2'd1,
    IM_RESP = 2'd2
  } im_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// 1R1W synchronous instruction word array.
// Read data register holds until the next read.
module instr_mem_array #(
  parameter int IWIDTH     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  im_clk,
  input  logic                  im_rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [IWIDTH-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [IWIDTH-1:0]     rdata
);

  logic [IWIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

  // Program-load write port; contents survive reset.
  always_ff @(posedge im_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-edge write is not yet visible.
  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-request responder: wait states, range check,
// one-cycle ack carrying one instruction word.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int IWIDTH       = IM_IWIDTH,
  parameter int AWIDTH_INSTR = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int LATENCY      = 1
) (
  input  logic                    im_clk,
  input  logic                    im_rst,
  input  logic                    im_i_syn,
  input  logic [AWIDTH_INSTR-1:0] im_i_addr,
  input  logic                    im_i_flush,
  output logic                    im_o_ready,
  output logic                    im_o_ack,
  output logic [IWIDTH-1:0]       im_o_instr,
  output logic                    im_o_err,
  input  logic                    im_i_we,
  input  logic [DEPTH_LOG2-1:0]   im_i_waddr,
  input  logic [IWIDTH-1:0]       im_i_wdata
);

  localparam int AW = AWIDTH_INSTR;
  localparam int DL = DEPTH_LOG2;
  localparam logic [3:0] LAT = 4'(LATENCY);

  im_state_e         state_q;
  logic [3:0]        cnt_q;
  logic [AW-1:0]     addr_q;
  logic              ack_q;
  logic              err_q;
  logic              ready_q;
  logic              nop_q;
  logic [IWIDTH-1:0] rdata;

  logic          accept;
  logic          fire;
  logic          bad;
  logic          rd_en;
  logic [AW-1:0] cur_addr;

  // Accept/fire decisions and the address range check.
  always_comb begin
    accept   = im_i_syn && !im_i_flush &&
               (state_q != IM_WAIT);
    fire     = 1'b0;
    if (!im_i_flush) begin
      if (state_q == IM_WAIT)
        fire = (cnt_q == 4'd1);
      else
        fire = accept && (LATENCY == 0);
    end
    cur_addr = accept ? im_i_addr : addr_q;
    bad      = (|cur_addr[1:0]) ||
               (|cur_addr[AW-1:DL+2]);
    rd_en    = fire && !bad;
  end

  instr_mem_array #(
    .IWIDTH    (IWIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .im_clk(im_clk),
    .im_rst(im_rst),
    .we    (im_i_we),
    .waddr (im_i_waddr),
    .wdata (im_i_wdata),
    .re    (rd_en),
    .raddr (cur_addr[DL+1:2]),
    .rdata (rdata)
  );

  // Request FSM with wait counter and registered outputs.
  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      state_q <= IM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      nop_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (im_i_flush) begin
        state_q <= IM_IDLE;
        cnt_q   <= '0;
        ready_q <= 1'b1;
      end else if (fire) begin
        state_q <= IM_RESP;
        cnt_q   <= '0;
        ack_q   <= 1'b1;
        err_q   <= bad;
        nop_q   <= bad;
        ready_q <= 1'b1;
        if (accept) addr_q <= im_i_addr;
      end else if (accept) begin
        state_q <= IM_WAIT;
        cnt_q   <= LAT;
        addr_q  <= im_i_addr;
        ready_q <= 1'b0;
      end else if (state_q == IM_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end else begin
        state_q <= IM_IDLE;
        ready_q <= 1'b1;
      end
    end
  end

  assign im_o_ready = ready_q;
  assign im_o_ack   = ack_q;
  assign im_o_err   = err_q;
  assign im_o_instr = nop_q ? IWIDTH'(IM_NOP) : rdata;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench: three responders with LATENCY 0/1/2 sharing
// the load port; directed table plus random vs model.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        syn   [3];
  logic [31:0] addr  [3];
  logic        flush [3];
  logic        ready [3];
  logic        ack   [3];
  logic [31:0] instr [3];
  logic        err   [3];
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_responder #(
      .IWIDTH      (32),
      .AWIDTH_INSTR(32),
      .DEPTH_LOG2  (10),
      .LATENCY     (g)
    ) u_dut (
      .im_clk    (clk),
      .im_rst    (rst_n),
      .im_i_syn  (syn[g]),
      .im_i_addr (addr[g]),
      .im_i_flush(flush[g]),
      .im_o_ready(ready[g]),
      .im_o_ack  (ack[g]),
      .im_o_instr(instr[g]),
      .im_o_err  (err[g]),
      .im_i_we   (we),
      .im_i_waddr(waddr),
      .im_i_wdata(wdata)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int ln,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got=%h want=%h t=%0t",
               nm, ln, act, exp, $time);
    end
  endtask

  // Reference model: each lane serves one request at a time;
  // a request accepted at edge e completes at edge e+lane.
  logic [31:0] mmem    [1024];
  bit          m_pend  [3];
  int          m_due   [3];
  logic [31:0] m_paddr [3];
  logic [31:0] m_last  [3];
  bit          e_ack   [3];
  bit          e_err   [3];
  bit          e_ready [3];
  int          ecyc;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i]  = 0;
      m_last[i]  = 0;
      e_ack[i]   = 0;
      e_err[i]   = 0;
      e_ready[i] = 1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit          fire;
      logic [31:0] a;
      fire     = 0;
      a        = 0;
      e_ack[i] = 0;
      e_err[i] = 0;
      if (flush[i]) begin
        m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (m_due[i] == ecyc) begin
          fire      = 1;
          a         = m_paddr[i];
          m_pend[i] = 0;
        end
      end else if (syn[i]) begin
        if (i == 0) begin
          fire = 1;
          a    = addr[i];
        end else begin
          m_pend[i]  = 1;
          m_due[i]   = ecyc + i;
          m_paddr[i] = addr[i];
        end
      end
      if (fire) begin
        e_ack[i]  = 1;
        e_err[i]  = (a % 4 != 0) || (a >= 4096);
        m_last[i] = e_err[i] ? NOP : mmem[a / 4];
      end
      e_ready[i] = !m_pend[i];
    end
    if (we) mmem[waddr] = wdata;
    ecyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model();
    for (int i = 0; i < 3; i++) begin
      chk("m_ack",   i, 32'(ack[i]),   32'(e_ack[i]));
      chk("m_err",   i, 32'(err[i]),   32'(e_err[i]));
      chk("m_instr", i, instr[i],      m_last[i]);
      chk("m_ready", i, 32'(ready[i]), 32'(e_ready[i]));
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      syn[i]   = 0;
      addr[i]  = 0;
      flush[i] = 0;
    end
    we    = 0;
    waddr = 0;
    wdata = 0;
  endtask

  typedef struct {
    int          ln;
    bit          s;
    logic [31:0] a;
    bit          f;
    bit          w;
    logic [9:0]  wa;
    logic [31:0] wd;
    bit          ea;
    bit          ee;
    logic [31:0] ei;
    bit          er;
  } vec_t;

  function automatic vec_t mk(
    int ln, bit s, logic [31:0] a, bit f,
    bit w, logic [9:0] wa, logic [31:0] wd,
    bit ea, bit ee, logic [31:0] ei, bit er);
    vec_t v;
    v.ln = ln; v.s = s; v.a = a; v.f = f;
    v.w = w; v.wa = wa; v.wd = wd;
    v.ea = ea; v.ee = ee; v.ei = ei; v.er = er;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] ra;
    int          r;

    // Expected rows: lane, syn, addr, flush, we, waddr, wdata,
    // ack, err, instr, ready (outputs just after that edge).
    // Array preloaded with word w = A000_0000 + w.
    // Lane 2 (two wait states), new data at word 3.
    tbl.push_back(mk(2,0,32'h0,0, 1,10'd3,32'h0050_0093, 0,0,32'h0,1));
    tbl.push_back(mk(2,1,32'hC,0, 0,10'd0,32'h0, 0,0,32'h0,0));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0,0));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 1,0,32'h0050_0093,1));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,1));
    // Lane 0 streaming one word per cycle.
    tbl.push_back(mk(0,1,32'h0,0, 0,10'd0,32'h0, 1,0,32'hA000_0000,1));
    tbl.push_back(mk(0,1,32'h4,0, 0,10'd0,32'h0, 1,0,32'hA000_0001,1));
    tbl.push_back(mk(0,1,32'h8,0, 0,10'd0,32'h0, 1,0,32'hA000_0002,1));
    tbl.push_back(mk(0,1,32'hC,0, 0,10'd0,32'h0, 1,0,32'h0050_0093,1));
    tbl.push_back(mk(0,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,1));
    // Lane 1 misaligned and out-of-range requests.
    tbl.push_back(mk(1,1,32'h6,0, 0,10'd0,32'h0, 0,0,32'h0,0));
    tbl.push_back(mk(1,0,32'h0,0, 0,10'd0,32'h0, 1,1,NOP,1));
    tbl.push_back(mk(1,1,32'h1000,0, 0,10'd0,32'h0, 0,0,NOP,0));
    tbl.push_back(mk(1,0,32'h0,0, 0,10'd0,32'h0, 1,1,NOP,1));
    tbl.push_back(mk(0,1,32'h1000,0, 0,10'd0,32'h0, 1,1,NOP,1));
    // Lane 2 flush while waiting, then a clean request.
    tbl.push_back(mk(2,1,32'h20,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,0));
    tbl.push_back(mk(2,1,32'h24,1, 0,10'd0,32'h0, 0,0,32'h0050_0093,1));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,1));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,1));
    tbl.push_back(mk(2,1,32'h10,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,0));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 0,0,32'h0050_0093,0));
    tbl.push_back(mk(2,0,32'h0,0, 0,10'd0,32'h0, 1,0,32'hA000_0004,1));
    // Lane 1 write on accept edge is seen; write on read edge is not.
    tbl.push_back(mk(1,1,32'h14,0, 1,10'd5,32'h1234_5678, 0,0,NOP,0));
    tbl.push_back(mk(1,0,32'h0,0, 0,10'd0,32'h0, 1,0,32'h1234_5678,1));
    tbl.push_back(mk(1,1,32'h18,0, 0,10'd0,32'h0, 0,0,32'h1234_5678,0));
    tbl.push_back(mk(1,0,32'h0,0, 1,10'd6,32'hDEAD_BEEF, 1,0,32'hA000_0006,1));
    // Lane 0: flush right after an ack, then resume.
    tbl.push_back(mk(0,1,32'h18,0, 0,10'd0,32'h0, 1,0,32'hDEAD_BEEF,1));
    tbl.push_back(mk(0,1,32'h4,1, 0,10'd0,32'h0, 0,0,32'hDEAD_BEEF,1));
    tbl.push_back(mk(0,1,32'h4,0, 0,10'd0,32'h0, 1,0,32'hA000_0001,1));

    idle_inputs();
    rst_n = 1'b0;
    ecyc  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack",   i, 32'(ack[i]),   32'd0);
      chk("rst_err",   i, 32'(err[i]),   32'd0);
      chk("rst_instr", i, instr[i],      32'd0);
      chk("rst_ready", i, 32'(ready[i]), 32'd1);
    end
    rst_n = 1'b1;

    for (int w = 0; w < 1024; w++) begin
      we    = 1;
      waddr = 10'(w);
      wdata = 32'hA000_0000 | 32'(w);
      step();
    end
    idle_inputs();

    foreach (tbl[k]) begin
      idle_inputs();
      syn[tbl[k].ln]   = tbl[k].s;
      addr[tbl[k].ln]  = tbl[k].a;
      flush[tbl[k].ln] = tbl[k].f;
      we    = tbl[k].w;
      waddr = tbl[k].wa;
      wdata = tbl[k].wd;
      step();
      chk($sformatf("t%0d_ack", k), tbl[k].ln,
          32'(ack[tbl[k].ln]), 32'(tbl[k].ea));
      chk($sformatf("t%0d_err", k), tbl[k].ln,
          32'(err[tbl[k].ln]), 32'(tbl[k].ee));
      chk($sformatf("t%0d_instr", k), tbl[k].ln,
          instr[tbl[k].ln], tbl[k].ei);
      chk($sformatf("t%0d_ready", k), tbl[k].ln,
          32'(ready[tbl[k].ln]), 32'(tbl[k].er));
    end
    idle_inputs();
    step();
    cmp_model();

    // Reset while lane 2 waits: outputs clear at once, no late ack.
    syn[2]  = 1;
    addr[2] = 32'h8;
    step();
    chk("pre_rst_ready", 2, 32'(ready[2]), 32'd0);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_ack",   i, 32'(ack[i]),   32'd0);
      chk("mid_rst_instr", i, instr[i],      32'd0);
      chk("mid_rst_ready", i, 32'(ready[i]), 32'd1);
      chk("mid_rst_err",   i, 32'(err[i]),   32'd0);
    end
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      step();
      cmp_model();
    end

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        syn[i]   = ($urandom_range(0, 9) < 7);
        flush[i] = ($urandom_range(0, 19) == 0);
        r = int'($urandom_range(0, 19));
        if (r == 0) begin
          ra = 32'($urandom_range(0, 1023)) * 4 +
               32'($urandom_range(1, 3));
        end else if (r == 1) begin
          ra = $urandom;
          if (ra < 32'd4096) ra = ra + 32'd4096;
        end else begin
          ra = 32'($urandom_range(0, 1023)) * 4;
        end
        addr[i] = ra;
      end
      we    = ($urandom_range(0, 4) == 0);
      waddr = 10'($urandom_range(0, 1023));
      wdata = $urandom;
      step();
      cmp_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
